// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush, NOP insertion on empty slots and a saturating bubble counter.
module pipe_stage_skid #(
    parameter int unsigned CTRL_W     = 9,
    parameter int unsigned DATA_W     = 111,
    parameter bit          CLEAR_DATA = 1'b1,
    parameter int unsigned BUB_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [BUB_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [BUB_W-1:0] BUB_MAX = '1;

    state_t              state_reg;
    state_t              state_next;
    logic                in_ready_reg;
    logic                out_valid_reg;
    logic [1:0]          occupancy_reg;
    logic [CTRL_W-1:0]   main_ctrl_reg;
    logic [DATA_W-1:0]   main_data_reg;
    logic [CTRL_W-1:0]   skid_ctrl_reg;
    logic [DATA_W-1:0]   skid_data_reg;
    logic [BUB_W-1:0]    bubble_cnt_reg;
    logic                push;
    logic                pop;

    assign push = in_valid & in_ready_reg;
    assign pop  = out_valid_reg & out_ready;

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (push) state_next = ST_FULL;
                ST_FULL: begin
                    if (push && !pop)      state_next = ST_SKID;
                    else if (!push && pop) state_next = ST_EMPTY;
                end
                ST_SKID:  if (pop) state_next = ST_FULL;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered from the next state, so in_ready never
    // sees out_ready combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_EMPTY;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            occupancy_reg  <= 2'd0;
            main_ctrl_reg  <= '0;
            main_data_reg  <= '0;
            skid_ctrl_reg  <= '0;
            skid_data_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != ST_SKID);
            out_valid_reg <= (state_next != ST_EMPTY);
            case (state_next)
                ST_FULL: occupancy_reg <= 2'd1;
                ST_SKID: occupancy_reg <= 2'd2;
                default: occupancy_reg <= 2'd0;
            endcase

            if (!out_valid_reg && bubble_cnt_reg != BUB_MAX)
                bubble_cnt_reg <= bubble_cnt_reg + BUB_W'(1);

            if (flush) begin
                main_ctrl_reg <= '0;
                skid_ctrl_reg <= '0;
                if (CLEAR_DATA) begin
                    main_data_reg <= '0;
                    skid_data_reg <= '0;
                end
            end else begin
                case (state_reg)
                    ST_EMPTY: begin
                        if (push) begin
                            main_ctrl_reg <= in_ctrl;
                            main_data_reg <= in_data;
                        end
                    end
                    ST_FULL: begin
                        if (push && pop) begin
                            main_ctrl_reg <= in_ctrl;
                            main_data_reg <= in_data;
                        end else if (push) begin
                            skid_ctrl_reg <= in_ctrl;
                            skid_data_reg <= in_data;
                        end else if (pop) begin
                            // Emptied slot presents a NOP
                            main_ctrl_reg <= '0;
                            if (CLEAR_DATA) main_data_reg <= '0;
                        end
                    end
                    ST_SKID: begin
                        if (pop) begin
                            main_ctrl_reg <= skid_ctrl_reg;
                            main_data_reg <= skid_data_reg;
                            skid_ctrl_reg <= '0;
                            if (CLEAR_DATA) skid_data_reg <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign out_ctrl   = main_ctrl_reg;
    assign out_data   = main_data_reg;
    assign occupancy  = occupancy_reg;
    assign bubble_cnt = bubble_cnt_reg;

endmodule
